// File: rtl/change_dispenser.sv
// change_dispenser: coin-output sequencer for the vending machine.
// Accepts a change amount in quarters over a req/ready handshake. It pays the
// change as timed pulses on the half-dollar and quarter eject lines, largest
// coin first, with a low gap after each pulse. It then strobes done for one
// cycle.
module change_dispenser #(
  parameter int AMT_W        = 3,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2
) (
  input  logic             CLK,
  input  logic             RES,
  input  logic             req,
  input  logic [AMT_W-1:0] amount_q,
  output logic             ready,
  output logic             busy,
  output logic             halfDollar_out,
  output logic             quarter_out,
  output logic             done,
  output logic [AMT_W-1:0] remaining_q
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PULSE,
    S_GAP,
    S_DONE
  } state_t;

  // The timer must be wide enough to reach the longer of the two phases.
  localparam int TMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TW-1:0] PULSE_LAST = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LAST   = TW'(GAP_CYCLES - 1);

  state_t           r_state;
  logic [TW-1:0]    r_timer;
  logic [AMT_W-1:0] r_remaining;
  logic             r_ready;
  logic             r_busy;
  logic             r_half;
  logic             r_quarter;
  logic             r_done;

  // The coin value the current pulse pays off, in quarters.
  logic [AMT_W-1:0] w_coin_value;
  assign w_coin_value = r_half ? AMT_W'(2) : AMT_W'(1);

  // Single-process sequencer. State, timer and all outputs are updated together.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side below reads the value from before the clock edge.
  always_ff @(posedge CLK) begin
    if (!RES) begin
      // NOTE: reset is synchronous. It abandons any dispense in progress, so
      // no partial pulse continues past the reset edge.
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_remaining <= '0;
      r_ready     <= 1'b1;
      r_busy      <= 1'b0;
      r_half      <= 1'b0;
      r_quarter   <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (req) begin
            r_ready <= 1'b0;
            r_timer <= '0;
            if (amount_q == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              // Pick the largest coin that does not overpay.
              r_state     <= S_PULSE;
              r_busy      <= 1'b1;
              r_remaining <= amount_q;
              r_half      <= (amount_q > AMT_W'(1));
              r_quarter   <= !(amount_q > AMT_W'(1));
            end
          end
        end

        S_PULSE: begin
          if (r_timer == PULSE_LAST) begin
            r_state     <= S_GAP;
            r_timer     <= '0;
            r_half      <= 1'b0;
            r_quarter   <= 1'b0;
            r_remaining <= r_remaining - w_coin_value;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        S_GAP: begin
          if (r_timer == GAP_LAST) begin
            r_timer <= '0;
            if (r_remaining != '0) begin
              r_state   <= S_PULSE;
              r_half    <= (r_remaining > AMT_W'(1));
              r_quarter <= !(r_remaining > AMT_W'(1));
            end else begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
          r_ready <= 1'b1;
        end

        default: begin
          r_state <= S_IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign ready          = r_ready;
  assign busy           = r_busy;
  assign halfDollar_out = r_half;
  assign quarter_out    = r_quarter;
  assign done           = r_done;
  assign remaining_q    = r_remaining;

endmodule

// File: tb/tb_change_dispenser.sv
// Testbench for change_dispenser.
// The reference model expands an amount into the per-cycle output trace that
// the coin-payment rules imply. It works coin by coin: greedy half-dollars
// first, each coin followed by its gap, then one done cycle and one idle cycle.
module tb_change_dispenser;

  localparam int AMT_W = 3;
  localparam int P     = 4;
  localparam int G     = 2;
  localparam int VW    = 5 + AMT_W;

  logic             CLK = 1'b0;
  logic             RES = 1'b0;
  logic             req = 1'b0;
  logic [AMT_W-1:0] amount_q = '0;
  logic             ready, busy, halfDollar_out, quarter_out, done;
  logic [AMT_W-1:0] remaining_q;

  int checks = 0;
  int errors = 0;

  logic [VW-1:0] exp_q[$];

  change_dispenser #(
    .AMT_W       (AMT_W),
    .PULSE_CYCLES(P),
    .GAP_CYCLES  (G)
  ) dut (
    .CLK           (CLK),
    .RES           (RES),
    .req           (req),
    .amount_q      (amount_q),
    .ready         (ready),
    .busy          (busy),
    .halfDollar_out(halfDollar_out),
    .quarter_out   (quarter_out),
    .done          (done),
    .remaining_q   (remaining_q)
  );

  always #5 CLK = ~CLK;

  // Output vector order: {ready, busy, half, quarter, done, remaining}.
  function automatic logic [VW-1:0] obs();
    return {ready, busy, halfDollar_out, quarter_out, done, remaining_q};
  endfunction

  function automatic logic [VW-1:0] pack(input bit rdy, input bit bsy, input bit h,
                                         input bit q, input bit d, input int rem);
    logic [AMT_W-1:0] r;
    r = AMT_W'(rem);
    return {rdy, bsy, h, q, d, r};
  endfunction

  // Expected trace, one entry per cycle after the acceptance edge.
  task automatic build_trace(input int amt);
    int rem;
    bit half;
    exp_q.delete();
    rem = amt;
    while (rem > 0) begin
      half = (rem >= 2);
      repeat (P) exp_q.push_back(pack(1'b0, 1'b1, half, !half, 1'b0, rem));
      rem = rem - (half ? 2 : 1);
      repeat (G) exp_q.push_back(pack(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, rem));
    end
    exp_q.push_back(pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0));
    exp_q.push_back(pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0));
  endtask

  // Issues one request and compares every cycle against the model trace.
  // With hold=1 the req line stays high and amount_q keeps toggling, so the
  // second request must be taken only on the cycle ready returns.
  task automatic run_and_compare(input int amt, input bit hold, input string name);
    logic [VW-1:0] got;
    int            k;
    bit            seen_done;
    build_trace(amt);
    @(negedge CLK);
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_before_req: got %b expected 1", name, ready);
    end
    req      = 1'b1;
    amount_q = AMT_W'(amt);
    k = 0;
    foreach (exp_q[i]) begin
      @(negedge CLK);
      got = obs();
      checks++;
      if (got !== exp_q[i]) begin
        errors++;
        $display("FAIL %s cycle%0d: got %b expected %b (rdy,bsy,half,qtr,done,rem)",
                 name, i + 1, got, exp_q[i]);
      end
      checks++;
      if (halfDollar_out && quarter_out) begin
        errors++;
        $display("FAIL %s both_lines cycle%0d: got 11 expected not both high", name, i + 1);
      end
      if (hold) amount_q = (amount_q == AMT_W'(2)) ? AMT_W'(1) : AMT_W'(2);
      else begin
        req      = 1'b0;
        amount_q = AMT_W'($urandom_range(0, 7));
      end
      k++;
    end
    if (hold) begin
      // Ready is high now and req is still asserted, so the next edge accepts 1.
      amount_q = AMT_W'(1);
      @(negedge CLK);
      got = obs();
      checks++;
      if (got !== pack(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1)) begin
        errors++;
        $display("FAIL %s second_accept: got %b expected %b", name, got,
                 pack(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1));
      end
      req = 1'b0;
      seen_done = 1'b0;
      for (int c = 0; c < 50 && !seen_done; c++) begin
        @(negedge CLK);
        if (done) seen_done = 1'b1;
      end
      checks++;
      if (!seen_done) begin
        errors++;
        $display("FAIL %s second_done: got no done within 50 cycles expected done", name);
      end
      @(negedge CLK);
    end
  endtask

  task automatic test_reset();
    RES = 1'b0;
    req = 1'b0;
    repeat (2) @(negedge CLK);
    RES = 1'b1;
    @(negedge CLK);
    checks++;
    if (obs() !== pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0)) begin
      errors++;
      $display("FAIL reset_idle: got %b expected %b", obs(), pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0));
    end
  endtask

  task automatic test_amount3();
    run_and_compare(3, 1'b0, "amount3");
  endtask

  task automatic test_zero();
    run_and_compare(0, 1'b0, "amount0");
  endtask

  task automatic test_max();
    run_and_compare(7, 1'b0, "amount7");
  endtask

  task automatic test_req_held();
    run_and_compare(2, 1'b1, "req_held");
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    req      = 1'b1;
    amount_q = AMT_W'(4);
    @(negedge CLK);
    req = 1'b0;
    @(negedge CLK);
    checks++;
    if (obs() !== pack(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4)) begin
      errors++;
      $display("FAIL reset_mid pulse2: got %b expected %b", obs(), pack(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4));
    end
    RES = 1'b0;
    @(negedge CLK);
    checks++;
    if (obs() !== pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0)) begin
      errors++;
      $display("FAIL reset_mid after: got %b expected %b", obs(), pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0));
    end
    RES = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge CLK);
      checks++;
      if (obs() !== pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0)) begin
        errors++;
        $display("FAIL reset_mid idle%0d: got %b expected idle, no done", c, obs());
      end
    end
    run_and_compare(1, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    int amt;
    for (int t = 0; t < 10; t++) begin
      amt = int'($urandom_range(0, 7));
      repeat ($urandom_range(0, 3)) @(negedge CLK);
      run_and_compare(amt, 1'b0, $sformatf("random%0d_a%0d", t, amt));
    end
  endtask

  initial begin
    test_reset();
    test_amount3();
    test_zero();
    test_max();
    test_req_held();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
- Coin-output sequencer for the vending machine: the outbound counterpart of the coin-input path.
- The vending FSM hands it a change amount in quarters with a req/ready handshake.
- It drives the physical halfDollar_out / quarter_out lines as timed pulses, largest coin first, separated by gaps.
- When all change is paid it raises a one-cycle done.
- It sits between the state/output logic and the board coin-out LEDs, on the same clock as the state register.

Parameters:
- AMT_W, 3: width of change amount in quarters (max 7 = $1.75).
- PULSE_CYCLES, 4: cycles each coin output is held high (>=1).
- GAP_CYCLES, 2: low cycles after each coin pulse (>=1).

Ports:
- CLK  input  1  system clock; all state changes on rising edge.
- RES  input  1  reset; synchronous, active-low.
- req  input  1  change request; sampled only when ready=1.
- amount_q  input  AMT_W  change owed, in quarters; captured on acceptance.
- ready  output  1  high in IDLE only.
- busy  output  1  high while dispensing (PULSE/GAP states).
- halfDollar_out  output  1  half-dollar eject pulse.
- quarter_out  output  1  quarter eject pulse.
- done  output  1  single-cycle completion strobe.
- remaining_q  output  AMT_W  quarters still owed.

Behaviour:
- All outputs are registered.
- Reset (RES=0 at an edge): state=IDLE, ready=1, busy=0, halfDollar_out=0, quarter_out=0, done=0, remaining_q=0, timers=0.
  - Reset takes effect from any state.
  - A dispense in progress is abandoned; no partial pulse continues after the reset edge.
- States:
  - IDLE (ready=1).
  - PULSE (one coin line high).
  - GAP (both low).
  - DONE (done=1 for exactly one cycle).
- IDLE: at an edge with req=1, the request is accepted.
  - If amount_q=0: go to DONE; no coin pulse.
  - Else: remaining_q<=amount_q; go to PULSE with the coin selected from amount_q.
  - From the next cycle, ready=0 and busy=1.
- Coin selection: on entry to each PULSE, select halfDollar if remaining>=2, else quarter.
  - Exactly one coin line is high in PULSE.
  - The two coin lines are never high together.
- PULSE: the selected line is high for exactly PULSE_CYCLES cycles.
  - On the final edge: line falls, remaining_q decrements by 2 (half) or 1 (quarter), go to GAP.
- GAP: both lines low for exactly GAP_CYCLES cycles.
  - Then go to PULSE if remaining_q>0, else DONE.
- DONE: done=1 and busy=0 for one cycle, then IDLE (ready=1 the following cycle).
- req while ready=0 is ignored; it is not queued.
- amount_q changes after acceptance have no effect.
- Coin count n = floor(a/2) + (a mod 2).
- busy duration = n*(PULSE_CYCLES+GAP_CYCLES) cycles; done follows immediately.
- Request-to-done latency for a>0 = n*(P+G)+1 cycles; for a=0, done is the cycle after acceptance.
- remaining_q never underflows; it holds 0 in DONE and IDLE after completion.
- Max amount (all ones) is handled without width overflow.

Test Plan:
- Reset then idle: RES=0 for 2 cycles, then 1 -> ready=1, busy=0, both coin lines 0, done=0, remaining_q=0.
- amount_q=3, req 1 cycle (P=4, G=2):
  - halfDollar_out high 4 cycles, remaining_q 3->1, low 2.
  - quarter_out high 4 cycles, remaining_q 1->0, low 2.
  - done high 1 cycle 12 cycles after acceptance, then ready=1.
- amount_q=0 -> no coin pulses; done=1 on the cycle after acceptance; ready=1 next cycle.
- amount_q=7 -> 3 halfDollar pulses then 1 quarter pulse; 24 busy cycles; remaining_q sequence 7,5,3,1,0; never both lines high.
- req held high continuously with amount_q toggling 2/1 during a dispense -> only the first amount is paid; a second request is accepted only on the cycle ready=1.
- RES=0 asserted in the 2nd cycle of a halfDollar pulse (amount_q=4) -> halfDollar_out=0, remaining_q=0, ready=1 after that edge; no done pulse; a new req of 1 then dispenses one quarter normally.
